// File: rtl/nfc_command_arbiter_if.sv
// -----------------------------------------------------------------------------
// nfc_command_arbiter_if
// Bundles the requester-side command/data signals and the ACG-side command bus
// of the NFC command arbiter.
//   slave  : arbiter view (requests and ACG status in, grant and ACG bus out)
//   master : requester/ACG environment view (the mirror of slave)
// Per-requester fields are packed; requester i owns slice [W*i +: W].
// -----------------------------------------------------------------------------
interface nfc_command_arbiter_if #(
    parameter int unsigned NumberOfWays       = 4,
    parameter int unsigned NumberOfRequesters = 4
);
    localparam int unsigned NR = NumberOfRequesters;

    // Requester side
    logic [NR-1:0]              iReq;
    logic [8*NR-1:0]            iReqCommand;
    logic [3*NR-1:0]            iReqCommandOption;
    logic [NumberOfWays*NR-1:0] iReqTargetWay;
    logic [16*NR-1:0]           iReqNumOfData;
    logic [NR-1:0]              iReqCASelect;
    logic [40*NR-1:0]           iReqCAData;
    logic [16*NR-1:0]           iReqWriteData;
    logic [NR-1:0]              iReqWriteLast;
    logic [NR-1:0]              iReqWriteValid;
    logic [NR-1:0]              iReqReadReady;

    // ACG status
    logic                       iACG_Ready;
    logic                       iACG_LastStep;

    // Arbiter outputs
    logic [NR-1:0]              oGrant;
    logic                       oBusy;
    logic [7:0]                 oACG_Command;
    logic [2:0]                 oACG_CommandOption;
    logic [NumberOfWays-1:0]    oACG_TargetWay;
    logic [15:0]                oACG_NumOfData;
    logic                       oACG_CASelect;
    logic [39:0]                oACG_CAData;
    logic [15:0]                oACG_WriteData;
    logic                       oACG_WriteLast;
    logic                       oACG_WriteValid;
    logic                       oACG_ReadReady;

    modport slave (
        input  iReq, iReqCommand, iReqCommandOption, iReqTargetWay, iReqNumOfData,
               iReqCASelect, iReqCAData, iReqWriteData, iReqWriteLast, iReqWriteValid,
               iReqReadReady, iACG_Ready, iACG_LastStep,
        output oGrant, oBusy, oACG_Command, oACG_CommandOption, oACG_TargetWay,
               oACG_NumOfData, oACG_CASelect, oACG_CAData, oACG_WriteData,
               oACG_WriteLast, oACG_WriteValid, oACG_ReadReady
    );

    modport master (
        output iReq, iReqCommand, iReqCommandOption, iReqTargetWay, iReqNumOfData,
               iReqCASelect, iReqCAData, iReqWriteData, iReqWriteLast, iReqWriteValid,
               iReqReadReady, iACG_Ready, iACG_LastStep,
        input  oGrant, oBusy, oACG_Command, oACG_CommandOption, oACG_TargetWay,
               oACG_NumOfData, oACG_CASelect, oACG_CAData, oACG_WriteData,
               oACG_WriteLast, oACG_WriteValid, oACG_ReadReady
    );
endinterface

// File: rtl/nfc_command_arbiter.sv
// -----------------------------------------------------------------------------
// nfc_command_arbiter
// Round-robin arbiter giving NumberOfRequesters command generators exclusive
// use of a single ACG command port. The winner's command fields are latched at
// grant time and held until the command completes; data-phase signals are
// passed through combinationally from the current owner.
// Ports:
//   iSystemClock : clock, rising edge
//   iReset_n     : asynchronous active-low reset
//   bus          : nfc_command_arbiter_if.slave (requests, ACG status, ACG bus)
// -----------------------------------------------------------------------------
module nfc_command_arbiter #(
    parameter int unsigned NumberOfWays       = 4,
    parameter int unsigned NumberOfRequesters = 4
) (
    input logic                  iSystemClock,
    input logic                  iReset_n,
    nfc_command_arbiter_if.slave bus
);
    localparam int unsigned NR   = NumberOfRequesters;
    localparam int unsigned IdxW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StRelease} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [2:0]              opt_q, opt_d;
    logic [NumberOfWays-1:0] way_q, way_d;
    logic [15:0]             nod_q, nod_d;
    logic                    casel_q, casel_d;
    logic [39:0]             cadata_q, cadata_d;

    // Per-requester views of the packed request fields
    logic [7:0]              req_cmd    [NR];
    logic [2:0]              req_opt    [NR];
    logic [NumberOfWays-1:0] req_way    [NR];
    logic [15:0]             req_nod    [NR];
    logic                    req_casel  [NR];
    logic [39:0]             req_cadata [NR];
    logic [15:0]             req_wdata  [NR];
    logic                    req_wlast  [NR];
    logic                    req_wvalid [NR];
    logic                    req_rready [NR];

    for (genvar g = 0; g < NR; g++) begin : g_unpack
        assign req_cmd[g]    = bus.iReqCommand[8*g +: 8];
        assign req_opt[g]    = bus.iReqCommandOption[3*g +: 3];
        assign req_way[g]    = bus.iReqTargetWay[NumberOfWays*g +: NumberOfWays];
        assign req_nod[g]    = bus.iReqNumOfData[16*g +: 16];
        assign req_casel[g]  = bus.iReqCASelect[g];
        assign req_cadata[g] = bus.iReqCAData[40*g +: 40];
        assign req_wdata[g]  = bus.iReqWriteData[16*g +: 16];
        assign req_wlast[g]  = bus.iReqWriteLast[g];
        assign req_wvalid[g] = bus.iReqWriteValid[g];
        assign req_rready[g] = bus.iReqReadReady[g];
    end

    // Round-robin search starting just after the last owner
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            cand     = (32'(last_q) + 32'd1 + i) % NR;
            cand_idx = IdxW'(cand);
            if (!win_found && bus.iReq[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cmd_d    = cmd_q;
        opt_d    = opt_q;
        way_d    = way_q;
        nod_d    = nod_q;
        casel_d  = casel_q;
        cadata_d = cadata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.iACG_Ready && win_found) begin
                    state_d  = StIssue;
                    owner_d  = win_idx;
                    cmd_d    = req_cmd[win_idx];
                    opt_d    = req_opt[win_idx];
                    way_d    = req_way[win_idx];
                    nod_d    = req_nod[win_idx];
                    casel_d  = req_casel[win_idx];
                    cadata_d = req_cadata[win_idx];
                end
            end
            StIssue: begin
                // Completion wins over acceptance so zero-length commands skip BUSY
                if (bus.iACG_LastStep) begin
                    state_d = StRelease;
                end else if (!bus.iACG_Ready) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus.iACG_LastStep) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            last_q   <= IdxW'(NR - 1);
            cmd_q    <= '0;
            opt_q    <= '0;
            way_q    <= '0;
            nod_q    <= '0;
            casel_q  <= 1'b1;
            cadata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cmd_q    <= cmd_d;
            opt_q    <= opt_d;
            way_q    <= way_d;
            nod_q    <= nod_d;
            casel_q  <= casel_d;
            cadata_q <= cadata_d;
        end
    end

    // Outputs decode from the state register so reset forces the idle bus at once
    always_comb begin
        bus.oGrant             = '0;
        bus.oBusy              = (state_q != StIdle);
        bus.oACG_Command       = 8'h00;
        bus.oACG_CommandOption = '0;
        bus.oACG_TargetWay     = '0;
        bus.oACG_NumOfData     = '0;
        bus.oACG_CASelect      = 1'b1;
        bus.oACG_CAData        = '0;
        bus.oACG_WriteData     = '0;
        bus.oACG_WriteLast     = 1'b0;
        bus.oACG_WriteValid    = 1'b0;
        bus.oACG_ReadReady     = 1'b0;
        if (state_q == StIssue || state_q == StBusy) begin
            bus.oGrant[owner_q]    = 1'b1;
            bus.oACG_Command       = cmd_q;
            bus.oACG_CommandOption = opt_q;
            bus.oACG_TargetWay     = way_q;
            bus.oACG_NumOfData     = nod_q;
            bus.oACG_CASelect      = casel_q;
            bus.oACG_CAData        = cadata_q;
            bus.oACG_WriteData     = req_wdata[owner_q];
            bus.oACG_WriteLast     = req_wlast[owner_q];
            bus.oACG_WriteValid    = req_wvalid[owner_q];
            bus.oACG_ReadReady     = req_rready[owner_q];
        end
    end
endmodule

// File: tb/tb_nfc_command_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nfc_command_arbiter
// Self-checking bench for nfc_command_arbiter. Expected grants and latched
// command fields are queued when requests are driven and compared when the
// arbiter raises a grant. Inputs are driven and outputs sampled 1 ns after
// the rising clock edge.
// -----------------------------------------------------------------------------
module tb_nfc_command_arbiter;
    localparam int unsigned Ways = 4;
    localparam int unsigned Nr   = 4;

    typedef struct {
        logic [3:0]  grant;
        logic [7:0]  cmd;
        logic [2:0]  opt;
        logic [3:0]  way;
        logic [15:0] nod;
        logic        casel;
        logic [39:0] cadata;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    nfc_command_arbiter_if #(.NumberOfWays(Ways), .NumberOfRequesters(Nr)) bus ();

    nfc_command_arbiter #(.NumberOfWays(Ways), .NumberOfRequesters(Nr)) dut (
        .iSystemClock (clk),
        .iReset_n     (rst_n),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Field values each requester presents; the bench's model of what gets latched
    function automatic exp_t make_exp(input int i, input logic [7:0] cmd);
        exp_t e;
        e.grant  = 4'(1 << i);
        e.cmd    = cmd;
        e.opt    = 3'(i + 1);
        e.way    = 4'(1 << i);
        e.nod    = 16'(16'h0100 + i);
        e.casel  = (i % 2 == 0) ? 1'b0 : 1'b1;
        e.cadata = 40'h5A_0000_0000 + 40'(i);
        return e;
    endfunction

    task automatic set_req_fields(input int i, input logic [7:0] cmd);
        exp_t e;
        e = make_exp(i, cmd);
        bus.iReqCommand[8*i +: 8]          = e.cmd;
        bus.iReqCommandOption[3*i +: 3]    = e.opt;
        bus.iReqTargetWay[Ways*i +: Ways]  = e.way;
        bus.iReqNumOfData[16*i +: 16]      = e.nod;
        bus.iReqCASelect[i]                = e.casel;
        bus.iReqCAData[40*i +: 40]         = e.cadata;
    endtask

    task automatic check_idle_bus(input string tag);
        check_eq({tag, "_grant"}, 64'(bus.oGrant), 64'd0);
        check_eq({tag, "_cmd"}, 64'(bus.oACG_Command), 64'h00);
        check_eq({tag, "_casel"}, 64'(bus.oACG_CASelect), 64'd1);
    endtask

    task automatic wait_grant(input int budget, output int waited);
        waited = 0;
        while (bus.oGrant == '0 && waited < budget) begin
            tick();
            waited++;
        end
        check_eq("grant_seen", 64'(bus.oGrant != '0), 64'd1);
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        check_eq({tag, "_sb_avail"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq({tag, "_grant"}, 64'(bus.oGrant), 64'(e.grant));
        check_eq({tag, "_cmd"}, 64'(bus.oACG_Command), 64'(e.cmd));
        check_eq({tag, "_opt"}, 64'(bus.oACG_CommandOption), 64'(e.opt));
        check_eq({tag, "_way"}, 64'(bus.oACG_TargetWay), 64'(e.way));
        check_eq({tag, "_nod"}, 64'(bus.oACG_NumOfData), 64'(e.nod));
        check_eq({tag, "_casel"}, 64'(bus.oACG_CASelect), 64'(e.casel));
        check_eq({tag, "_cadata"}, 64'(bus.oACG_CAData), 64'(e.cadata));
        check_eq({tag, "_busy"}, 64'(bus.oBusy), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        check_eq("rst_busy", 64'(bus.oBusy), 64'd0);
        check_idle_bus("rst");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        rst_n                 = 1'b0;
        bus.iReq              = '0;
        bus.iReqCommand       = '0;
        bus.iReqCommandOption = '0;
        bus.iReqTargetWay     = '0;
        bus.iReqNumOfData     = '0;
        bus.iReqCASelect      = '0;
        bus.iReqCAData        = '0;
        bus.iReqWriteData     = '0;
        bus.iReqWriteLast     = '0;
        bus.iReqWriteValid    = '0;
        bus.iReqReadReady     = '0;
        bus.iACG_Ready        = 1'b0;
        bus.iACG_LastStep     = 1'b0;
        do_reset();

        // Single request, latching, pass-through and hold of latched fields
        set_req_fields(0, 8'h30);
        bus.iReq       = 4'b0001;
        bus.iACG_Ready = 1'b1;
        sb.push_back(make_exp(0, 8'h30));
        tick();
        pop_and_check("first");
        bus.iACG_Ready = 1'b0;
        tick();
        bus.iReqWriteData[15:0] = 16'hABCD;
        bus.iReqWriteValid[0]   = 1'b1;
        bus.iReqWriteLast[0]    = 1'b1;
        bus.iReqWriteData[31:16] = 16'h1111;
        #1;
        check_eq("pt_wdata", 64'(bus.oACG_WriteData), 64'hABCD);
        check_eq("pt_wvalid", 64'(bus.oACG_WriteValid), 64'd1);
        check_eq("pt_wlast", 64'(bus.oACG_WriteLast), 64'd1);
        bus.iReqCommand[7:0] = 8'hFF;
        bus.iReq             = 4'b0000;
        tick();
        check_eq("hold_cmd", 64'(bus.oACG_Command), 64'h30);
        check_eq("hold_grant", 64'(bus.oGrant), 64'b0001);
        bus.iACG_LastStep = 1'b1;
        tick();
        bus.iACG_LastStep = 1'b0;
        check_idle_bus("release");
        check_eq("release_busy", 64'(bus.oBusy), 64'd1);
        check_eq("release_wvalid", 64'(bus.oACG_WriteValid), 64'd0);
        bus.iReqWriteValid = '0;
        bus.iReqWriteLast  = '0;
        bus.iReqWriteData  = '0;
        tick();
        check_eq("idle_busy", 64'(bus.oBusy), 64'd0);

        // Round robin with all requesters held; reset restores index 0 priority
        do_reset();
        for (int i = 0; i < 4; i++) set_req_fields(i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) sb.push_back(make_exp(k % 4, 8'(8'h10 + (k % 4))));
        bus.iReq       = 4'b1111;
        bus.iACG_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(8, waited);
            check_eq($sformatf("rr%0d_wait", k), 64'(waited), 64'd1);
            pop_and_check($sformatf("rr%0d", k));
            bus.iACG_Ready = 1'b0;
            tick();
            bus.iACG_LastStep = 1'b1;
            tick();
            bus.iACG_LastStep = 1'b0;
            bus.iACG_Ready    = 1'b1;
            check_idle_bus($sformatf("rr%0d_rel", k));
            tick();
            check_eq($sformatf("rr%0d_gap", k), 64'(bus.oGrant), 64'd0);
        end
        bus.iReq = 4'b0000;
        tick();

        // Zero-length command: LastStep during the first ISSUE cycle
        set_req_fields(2, 8'h44);
        bus.iReq = 4'b0100;
        sb.push_back(make_exp(2, 8'h44));
        wait_grant(8, waited);
        pop_and_check("zlen");
        bus.iACG_LastStep = 1'b1;
        tick();
        bus.iACG_LastStep = 1'b0;
        bus.iReq          = 4'b0000;
        check_idle_bus("zlen_rel");
        check_eq("zlen_busy", 64'(bus.oBusy), 64'd1);
        tick();
        check_eq("zlen_idle", 64'(bus.oBusy), 64'd0);

        // Pending request while the ACG is not ready; LastStep in IDLE ignored
        set_req_fields(1, 8'h55);
        bus.iACG_Ready    = 1'b0;
        bus.iReq          = 4'b0010;
        bus.iACG_LastStep = 1'b1;
        tick();
        bus.iACG_LastStep = 1'b0;
        tick();
        tick();
        check_eq("notrdy_grant", 64'(bus.oGrant), 64'd0);
        check_eq("notrdy_busy", 64'(bus.oBusy), 64'd0);
        bus.iACG_Ready = 1'b1;
        sb.push_back(make_exp(1, 8'h55));
        tick();
        pop_and_check("rdy_rise");
        bus.iACG_Ready = 1'b0;
        tick();

        // Asynchronous abort during BUSY, then first grant right after release
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_bus("abort");
        check_eq("abort_busy", 64'(bus.oBusy), 64'd0);
        #2;
        rst_n          = 1'b1;
        bus.iACG_Ready = 1'b1;
        sb.push_back(make_exp(1, 8'h55));
        tick();
        pop_and_check("post_rst");

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
